// File: rtl/simon_seq_core.sv
// Simon game core: LFSR-built sequence, timed playback, and player-press checking.
// Buttons are active-low and asynchronous. They are synchronised, then converted to falling-edge events.
module simon_seq_core #(
  parameter int          NUM_BTN        = 3,
  parameter int          MAX_LEN        = 15,
  parameter int          SHOW_CYCLES    = 50000000,
  parameter int          GAP_CYCLES     = 12500000,
  parameter int          TIMEOUT_CYCLES = 250000000,
  parameter logic [15:0] LFSR_SEED      = 16'hACE1,
  localparam int         SYM_W          = ($clog2(NUM_BTN) < 1) ? 1 : $clog2(NUM_BTN),
  localparam int         LEN_W          = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [NUM_BTN-1:0] btn,
  output logic               show_valid,
  output logic [SYM_W-1:0]   show_sym,
  output logic [LEN_W-1:0]   level,
  output logic               in_wait,
  output logic               press_ok,
  output logic               win,
  output logic               lose
);

  // state    | meaning
  // IDLE     | waiting for start
  // ADD      | append one symbol, restart playback
  // SHOW_ON  | symbol idx displayed
  // SHOW_GAP | blank between symbols
  // WAIT_IN  | checking player presses
  // WIN/LOSE | result held until start
  typedef enum logic [2:0] {IDLE, ADD, SHOW_ON, SHOW_GAP, WAIT_IN, WIN, LOSE} state_t;

  localparam int ADDR_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int T_MAX1 = (SHOW_CYCLES > GAP_CYCLES) ? SHOW_CYCLES : GAP_CYCLES;
  localparam int T_MAX  = (T_MAX1 > TIMEOUT_CYCLES) ? T_MAX1 : TIMEOUT_CYCLES;
  localparam int TMR_W  = $clog2(T_MAX + 1);
  localparam logic [TMR_W-1:0] SHOW_LAST = TMR_W'(SHOW_CYCLES - 1);
  localparam logic [TMR_W-1:0] GAP_LAST  = TMR_W'(GAP_CYCLES - 1);
  localparam logic [TMR_W-1:0] TO_LAST   = TMR_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);
  localparam logic [15:0]      SEED      = (LFSR_SEED == 16'h0000) ? 16'hACE1 : LFSR_SEED;
  localparam logic [SYM_W:0]   NB_X      = (SYM_W + 1)'(NUM_BTN);

  state_t             state, state_nx;
  logic [LEN_W-1:0]   level_nx, idx, idx_nx;
  logic [TMR_W-1:0]   tmr, tmr_nx;
  logic [15:0]        lfsr;
  logic [NUM_BTN-1:0] sync1, sync2, prev, pe, exp_mask;
  logic [SYM_W-1:0]   seq_mem [2**ADDR_W];
  logic [SYM_W-1:0]   raw, sym_new, cur_sym, rd_sym;
  logic [SYM_W:0]     raw_x;
  logic               wr_en, ok_nx, last_sym;

  assign pe       = prev & ~sync2;
  assign raw      = lfsr[SYM_W-1:0];
  assign raw_x    = {1'b0, raw};
  assign sym_new  = (raw_x >= NB_X) ? SYM_W'(raw_x - NB_X) : raw;
  assign cur_sym  = seq_mem[idx[ADDR_W-1:0]];
  assign exp_mask = {{(NUM_BTN-1){1'b0}}, 1'b1} << cur_sym;
  assign last_sym = (idx == level - LEN_W'(1));

  always_comb begin
    state_nx = state;
    level_nx = level;
    idx_nx   = idx;
    tmr_nx   = '0;
    ok_nx    = 1'b0;
    wr_en    = 1'b0;
    case (state)
      IDLE, WIN, LOSE: begin
        if (start) begin
          state_nx = ADD;
          level_nx = '0;
        end
      end
      ADD: begin
        wr_en    = 1'b1;
        level_nx = level + LEN_W'(1);
        idx_nx   = '0;
        state_nx = SHOW_ON;
      end
      SHOW_ON: begin
        tmr_nx = tmr + TMR_W'(1);
        if (tmr == SHOW_LAST) state_nx = SHOW_GAP;
      end
      SHOW_GAP: begin
        tmr_nx = tmr + TMR_W'(1);
        if (tmr == GAP_LAST) begin
          if (last_sym) begin
            state_nx = WAIT_IN;
            idx_nx   = '0;
          end else begin
            state_nx = SHOW_ON;
            idx_nx   = idx + LEN_W'(1);
          end
        end
      end
      WAIT_IN: begin
        tmr_nx = tmr + TMR_W'(1);
        // A press in the expiry cycle wins over the timeout.
        if (pe != '0) begin
          if (pe == exp_mask) begin
            ok_nx = 1'b1;
            if (!last_sym) begin
              idx_nx = idx + LEN_W'(1);
              tmr_nx = '0;
            end else if (level == LEN_W'(MAX_LEN)) begin
              state_nx = WIN;
            end else begin
              state_nx = ADD;
            end
          end else begin
            state_nx = LOSE;
          end
        end else if (TIMEOUT_CYCLES != 0 && tmr == TO_LAST) begin
          state_nx = LOSE;
        end
      end
      default: state_nx = IDLE;
    endcase
    if (state_nx != state) tmr_nx = '0;
  end

  // The first symbol is shown the cycle after it is written, so bypass the memory.
  assign rd_sym = (wr_en && idx_nx[ADDR_W-1:0] == level[ADDR_W-1:0]) ? sym_new
                                                                     : seq_mem[idx_nx[ADDR_W-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      level      <= '0;
      idx        <= '0;
      tmr        <= '0;
      lfsr       <= SEED;
      sync1      <= '1;
      sync2      <= '1;
      prev       <= '1;
      show_valid <= 1'b0;
      show_sym   <= '0;
      in_wait    <= 1'b0;
      press_ok   <= 1'b0;
      win        <= 1'b0;
      lose       <= 1'b0;
    end else begin
      state      <= state_nx;
      level      <= level_nx;
      idx        <= idx_nx;
      tmr        <= tmr_nx;
      lfsr       <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      sync1      <= btn;
      sync2      <= sync1;
      prev       <= sync2;
      show_valid <= (state_nx == SHOW_ON);
      show_sym   <= (state_nx == SHOW_ON) ? rd_sym : '0;
      in_wait    <= (state_nx == WAIT_IN);
      press_ok   <= ok_nx;
      win        <= (state_nx == WIN);
      lose       <= (state_nx == LOSE);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en && !rst) seq_mem[level[ADDR_W-1:0]] <= sym_new;
  end

endmodule

// File: tb/tb_simon_seq_core.sv
// Directed bench for simon_seq_core: a cycle table for playback/timeout/reset, then hand-written game sequences.
module tb_simon_seq_core;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [2:0] btn = 3'b111;
  logic       show_valid, in_wait, press_ok, win, lose;
  logic [1:0] show_sym;
  logic [2:0] level;

  simon_seq_core #(
    .NUM_BTN(3), .MAX_LEN(4), .SHOW_CYCLES(4), .GAP_CYCLES(2),
    .TIMEOUT_CYCLES(20), .LFSR_SEED(16'hACE1)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .btn(btn),
    .show_valid(show_valid), .show_sym(show_sym), .level(level),
    .in_wait(in_wait), .press_ok(press_ok), .win(win), .lose(lose)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic r;
    logic s;
    int   lvl;
    int   sv;
    int   sym;   // -1: not checked
    int   iw;
    int   lo;
  } vec_t;

  vec_t        tbl [40];
  int          nv = 0;
  int          n_tests = 0, n_fail = 0;
  int          ok_count = 0;
  int          exp_seq [64];
  int          prev_level = 0;
  int          first_sym = 0;
  logic [15:0] m_lfsr = 16'hACE1, m_last = 16'hACE1;

  function automatic logic [15:0] lfsr_nxt(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

  function automatic int sym_of(input logic [15:0] v);
    int raw;
    raw = int'(v[1:0]);
    return (raw >= 3) ? raw - 3 : raw;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock: advance the LFSR model, sample at the falling edge, learn newly added symbols.
  task automatic tick();
    @(posedge clk);
    m_last = m_lfsr;
    m_lfsr = rst ? 16'hACE1 : lfsr_nxt(m_lfsr);
    @(negedge clk);
    if (level == 3'd0) prev_level = 0;
    else if (int'(level) > prev_level) begin
      exp_seq[int'(level) - 1] = sym_of(m_last);
      prev_level = int'(level);
    end
    if (press_ok) ok_count++;
  endtask

  task automatic addv(input logic r, input logic s, input int lvl, input int sv,
                      input int sym, input int iw, input int lo);
    tbl[nv] = '{r: r, s: s, lvl: lvl, sv: sv, sym: sym, iw: iw, lo: lo};
    nv++;
  endtask

  task automatic start_game();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Called in the ADD cycle; returns in the first WAIT_IN cycle.
  task automatic watch_show(input int rnd);
    int on_len = 0;
    int shown = 0;
    for (int c = 0; c < 300 && !in_wait; c++) begin
      tick();
      if (show_valid) begin
        if (on_len == 0) begin
          check("show_sym", int'(show_sym), exp_seq[shown]);
          if (shown == 0) first_sym = int'(show_sym);
          shown++;
        end
        on_len++;
      end else if (on_len != 0) begin
        check("show_len", on_len, 4);
        on_len = 0;
      end
    end
    check("in_wait_reached", int'(in_wait), 1);
    check("shown_count", shown, rnd);
  endtask

  task automatic press(input int b, input int exp_ok);
    btn[b] = 1'b0;
    repeat (3) tick();
    check("press_ok", int'(press_ok), exp_ok);
    btn = 3'b111;
  endtask

  task automatic settle();
    repeat (3) tick();
  endtask

  task automatic play_round(input int rnd);
    watch_show(rnd);
    for (int k = 0; k < rnd; k++) begin
      press(exp_seq[k], 1);
      if (k < rnd - 1) settle();
    end
  endtask

  initial begin
    int ok0, s1;

    // Cycle table: reset, first round playback, timeout, restart, reset during SHOW_ON.
    addv(1, 0, 0, 0, 0, 0, 0);
    addv(1, 1, 0, 0, 0, 0, 0);
    addv(0, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) addv(0, 0, 1, 1, 0, 0, 0);
    for (int i = 0; i < 2; i++) addv(0, 0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 20; i++) addv(0, 0, 1, 0, 0, 1, 0);
    addv(0, 0, 1, 0, 0, 0, 1);
    addv(0, 0, 1, 0, 0, 0, 1);
    addv(0, 1, 0, 0, 0, 0, 0);
    addv(0, 1, 1, 1, -1, 0, 0);
    addv(1, 0, 0, 0, 0, 0, 0);
    addv(0, 0, 0, 0, 0, 0, 0);

    for (int i = 0; i < nv; i++) begin
      rst   = tbl[i].r;
      start = tbl[i].s;
      tick();
      check($sformatf("row%0d_level", i), int'(level), tbl[i].lvl);
      check($sformatf("row%0d_show_valid", i), int'(show_valid), tbl[i].sv);
      check($sformatf("row%0d_in_wait", i), int'(in_wait), tbl[i].iw);
      check($sformatf("row%0d_lose", i), int'(lose), tbl[i].lo);
      check($sformatf("row%0d_win", i), int'(win), 0);
      if (tbl[i].sym >= 0) check($sformatf("row%0d_show_sym", i), int'(show_sym), tbl[i].sym);
    end
    rst = 1'b0;
    start = 1'b0;

    // Full game to WIN.
    ok0 = ok_count;
    start_game();
    for (int r = 1; r <= 4; r++) play_round(r);
    check("win", int'(win), 1);
    check("win_level", int'(level), 4);
    check("win_in_wait", int'(in_wait), 0);
    check("press_ok_pulses", ok_count - ok0, 10);
    repeat (5) tick();
    check("win_held", int'(win), 1);
    start_game();
    check("win_cleared", int'(win), 0);
    check("restart_level", int'(level), 0);

    // Wrong symbol on the second press of round 2.
    play_round(1);
    watch_show(2);
    press(exp_seq[0], 1);
    settle();
    press((exp_seq[1] + 1) % 3, 0);
    check("wrong_lose", int'(lose), 1);
    check("wrong_level", int'(level), 2);
    check("wrong_in_wait", int'(in_wait), 0);
    ok0 = ok_count;
    settle();
    press(0, 0);
    settle();
    press(2, 0);
    settle();
    check("lose_held", int'(lose), 1);
    check("lose_ignores_btn", ok_count - ok0, 0);

    // Correct press landing on timer value 19; the timer then restarts.
    start_game();
    play_round(1);
    watch_show(2);
    repeat (17) tick();
    btn[exp_seq[0]] = 1'b0;
    repeat (2) tick();
    check("late_press_no_lose", int'(lose), 0);
    check("late_press_in_wait", int'(in_wait), 1);
    tick();
    check("late_press_ok", int'(press_ok), 1);
    check("late_press_lose", int'(lose), 0);
    btn = 3'b111;
    repeat (19) tick();
    check("restart_tmr_c39_lose", int'(lose), 0);
    check("restart_tmr_c39_wait", int'(in_wait), 1);
    tick();
    check("restart_tmr_c40_lose", int'(lose), 1);
    check("restart_tmr_c40_wait", int'(in_wait), 0);

    // Two buttons falling together.
    start_game();
    watch_show(1);
    btn[0] = 1'b0;
    btn[1] = 1'b0;
    repeat (3) tick();
    check("double_lose", int'(lose), 1);
    check("double_press_ok", int'(press_ok), 0);
    btn = 3'b111;
    settle();

    // Button held through playback produces no event.
    start_game();
    btn[0] = 1'b0;
    ok0 = ok_count;
    watch_show(1);
    repeat (5) tick();
    check("held_in_wait", int'(in_wait), 1);
    check("held_no_lose", int'(lose), 0);
    check("held_no_ok", ok_count - ok0, 0);
    btn = 3'b111;
    settle();
    press(exp_seq[0], 1);

    // Reset during SHOW_ON of round 3.
    watch_show(2);
    press(exp_seq[0], 1);
    settle();
    press(exp_seq[1], 1);
    repeat (2) tick();
    check("r3_showing", int'(show_valid), 1);
    rst = 1'b1;
    tick();
    check("rst_show_valid", int'(show_valid), 0);
    check("rst_level", int'(level), 0);
    check("rst_in_wait", int'(in_wait), 0);
    check("rst_show_sym", int'(show_sym), 0);

    // Same reset-to-start distance gives the same first symbol.
    rst = 1'b0;
    repeat (7) tick();
    start_game();
    watch_show(1);
    s1 = first_sym;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (7) tick();
    start_game();
    watch_show(1);
    check("repeatable_first_sym", first_sym, s1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
